// File: rtl/bf_cmd_pkg.sv
// rtl/bf_cmd_pkg.sv - shared beamformer command frame types, constants and checksum
package bf_cmd_pkg;

    localparam int         FRAME_BYTES = 5;
    localparam logic [1:0] OPC_WRITE   = 2'b10;

    typedef struct packed {
        logic       tx;
        logic [2:0] lane;
        logic [4:0] row;
        logic [4:0] col;
        logic [5:0] phase;
    } bf_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DECODE
    } bf_rx_state_t;

    // Frame checksum byte: XOR of the four payload bytes
    function automatic logic [7:0] bf_cmd_csum(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2, input logic [7:0] b3);
        return b0 ^ b1 ^ b2 ^ b3;
    endfunction

endpackage

// File: rtl/bf_spi_cmd_rx_if.sv
// rtl/bf_spi_cmd_rx_if.sv - SPI command link wires (sclk/cs_n/mosi) with master/slave views
interface bf_spi_cmd_rx_if;
    logic sclk;
    logic cs_n;
    logic mosi;

    modport master (output sclk, output cs_n, output mosi);
    modport slave  (input  sclk, input  cs_n, input  mosi);
endinterface

// File: rtl/spi_slave_byte_rx.sv
// rtl/spi_slave_byte_rx.sv - SPI mode-0 oversampling synchroniser, edge detector and byte shifter
module spi_slave_byte_rx #(
    parameter int SYNC_FF = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bf_spi_cmd_rx_if.slave        spi,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    output logic                  cs_fall,
    output logic                  cs_rise,
    output logic                  cs_mid,
    output logic                  busy
);

    logic [SYNC_FF-1:0] sclk_sync, cs_sync, mosi_sync;
    logic               sclk_s, cs_s, mosi_s;
    logic               sclk_d, cs_d;
    logic [2:0]         bit_cnt;
    logic [6:0]         shreg;
    logic               sclk_rise, bit_take, byte_done;

    assign sclk_s    = sclk_sync[SYNC_FF-1];
    assign cs_s      = cs_sync[SYNC_FF-1];
    assign mosi_s    = mosi_sync[SYNC_FF-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    // Gate on the previous cs level so a bit edge landing with the cs_n rise still counts
    assign bit_take  = sclk_rise & ~cs_d;
    assign byte_done = bit_take & (bit_cnt == 3'd7);
    assign busy      = ~cs_d;

    // Synchroniser chains; cs_n resets to the inactive (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_FF-2:0], spi.sclk};
            cs_sync   <= {cs_sync[SYNC_FF-2:0], spi.cs_n};
            mosi_sync <= {mosi_sync[SYNC_FF-2:0], spi.mosi};
        end
    end

    // Bit shifter, byte strobe and registered cs_n edge flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d     <= 1'b0;
            cs_d       <= 1'b1;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            cs_fall    <= 1'b0;
            cs_rise    <= 1'b0;
            cs_mid     <= 1'b0;
        end else begin
            sclk_d     <= sclk_s;
            cs_d       <= cs_s;
            byte_valid <= byte_done;
            cs_fall    <= ~cs_s & cs_d;
            cs_rise    <= cs_s & ~cs_d;
            cs_mid     <= cs_s & ~cs_d & (bit_take ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0));
            if (cs_d) begin
                bit_cnt <= '0;
            end else if (bit_take) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (bit_take) begin
                shreg <= {shreg[5:0], mosi_s};
            end
            if (byte_done) begin
                byte_data <= {shreg, mosi_s};
            end
        end
    end

endmodule

// File: rtl/bf_spi_cmd_rx.sv
// rtl/bf_spi_cmd_rx.sv - beamformer SPI command receiver: frame FSM, decode, counters (option BF_RX_CSUM_EN)
module bf_spi_cmd_rx
    import bf_cmd_pkg::*;
#(
    parameter int LANE_ID = 0,
    parameter int SYNC_FF = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    bf_spi_cmd_rx_if.slave    spi,
    output logic              cmd_valid,
    output logic              cmd_tx,
    output logic [4:0]        cmd_row,
    output logic [4:0]        cmd_col,
    output logic [5:0]        cmd_phase,
    output logic              frame_err,
    output logic              csum_err,
    output logic              lane_miss,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy
);

    logic         byte_valid, cs_fall, cs_rise, cs_mid;
    logic [7:0]   byte_data;
    bf_rx_state_t state_q, state_d;
    logic [2:0]   byte_cnt_q, byte_cnt_d;
    logic [1:0]   opc_q;
    bf_cmd_t      cmd_q;
    logic         byte_take, frame_done, abort, csum_bad;
    logic         dec_ferr, dec_cerr, dec_miss, dec_ok;

    spi_slave_byte_rx #(.SYNC_FF(SYNC_FF)) u_byte_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi        (spi),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .cs_fall    (cs_fall),
        .cs_rise    (cs_rise),
        .cs_mid     (cs_mid),
        .busy       (busy)
    );

    assign byte_take = byte_valid & (state_q != ST_IDLE);

    // Frame FSM next state and byte counting
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_SHIFT;
                    byte_cnt_d = '0;
                end
            end
            ST_SHIFT, ST_DECODE: begin
                if (state_q == ST_DECODE) state_d = ST_SHIFT;
                if (byte_take) begin
                    if (byte_cnt_q == 3'(FRAME_BYTES - 1)) begin
                        frame_done = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = ST_DECODE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
                if (cs_rise) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign abort = cs_rise & (state_q != ST_IDLE) & (cs_mid | (byte_cnt_d != 3'd0));

`ifdef BF_RX_CSUM_EN
    logic [3:0][7:0] raw_q;

    // Keep the four payload bytes for the checksum compare against byte 4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
        end else if (byte_take && byte_cnt_q < 3'd4) begin
            raw_q[byte_cnt_q[1:0]] <= byte_data;
        end
    end

    assign csum_bad = bf_cmd_csum(raw_q[0], raw_q[1], raw_q[2], raw_q[3]) != byte_data;
`else
    assign csum_bad = 1'b0;
`endif

    assign dec_ferr = frame_done & (opc_q != OPC_WRITE);
    assign dec_cerr = frame_done & (opc_q == OPC_WRITE) & csum_bad;
    assign dec_miss = frame_done & (opc_q == OPC_WRITE) & ~csum_bad & (cmd_q.lane != 3'(LANE_ID));
    assign dec_ok   = frame_done & (opc_q == OPC_WRITE) & ~csum_bad & (cmd_q.lane == 3'(LANE_ID));

    // State register and per-byte field capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            opc_q      <= '0;
            cmd_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            if (byte_take) begin
                case (byte_cnt_q)
                    3'd0: begin
                        opc_q    <= byte_data[7:6];
                        cmd_q.tx   <= byte_data[5];
                        cmd_q.lane <= byte_data[4:2];
                    end
                    3'd1:    cmd_q.row   <= byte_data[4:0];
                    3'd2:    cmd_q.col   <= byte_data[4:0];
                    3'd3:    cmd_q.phase <= byte_data[5:0];
                    default: ;
                endcase
            end
        end
    end

    // Registered strobes, held command fields and event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            csum_err  <= 1'b0;
            lane_miss <= 1'b0;
            cmd_tx    <= 1'b0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            cmd_phase <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            cmd_valid <= dec_ok;
            frame_err <= dec_ferr | abort;
            csum_err  <= dec_cerr;
            lane_miss <= dec_miss;
            if (dec_ok) begin
                cmd_tx    <= cmd_q.tx;
                cmd_row   <= cmd_q.row;
                cmd_col   <= cmd_q.col;
                cmd_phase <= cmd_q.phase;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if ((dec_ferr | abort | dec_cerr) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
